// File: rtl/pc_predict_if.sv
// Fetch-stage bundle between the pipeline and the PC/branch-predictor stage.
// The master side drives stall/redirect/training; the slave side returns the
// fetch address, prediction and flush.
interface pc_predict_if #(
  parameter int unsigned XLEN = 32
);
  logic            i_stall;
  logic            i_redirect;
  logic [XLEN-1:0] i_redirect_addr;
  logic            i_upd_vld;
  logic [XLEN-1:0] i_upd_pc;
  logic [XLEN-1:0] i_upd_target;
  logic            i_upd_taken;
  logic [XLEN-1:0] o_imem_raddr;
  logic            o_pred_taken;
  logic [XLEN-1:0] o_pred_target;
  logic [XLEN-1:0] o_nxt_pc;
  logic            o_flush;

  modport master (
    output i_stall, i_redirect, i_redirect_addr,
    output i_upd_vld, i_upd_pc, i_upd_target, i_upd_taken,
    input  o_imem_raddr, o_pred_taken, o_pred_target, o_nxt_pc, o_flush
  );

  modport slave (
    input  i_stall, i_redirect, i_redirect_addr,
    input  i_upd_vld, i_upd_pc, i_upd_target, i_upd_taken,
    output o_imem_raddr, o_pred_taken, o_pred_target, o_nxt_pc, o_flush
  );
endinterface

// File: rtl/pc_predict.sv
// Program-counter stage with a direct-mapped branch target buffer and 2-bit
// saturating direction counters. Lookup is combinational on the current PC;
// training writes land at the clock edge and are seen from the next cycle.
// The BTB lives in flops because reset must invalidate every entry at once.
module pc_predict #(
  parameter int unsigned     XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_ADDR  = '0,
  parameter int unsigned     BTB_ENTRIES = 16
) (
  input logic         i_clk,
  input logic         i_rst_n,
  pc_predict_if.slave bus
);

  localparam int unsigned IDX  = $clog2(BTB_ENTRIES);
  localparam int unsigned TAGW = XLEN - IDX - 2;

  typedef struct packed {
    logic            valid;
    logic [TAGW-1:0] tag;
    logic [XLEN-1:0] target;
    logic [1:0]      ctr;
  } btb_entry_t;

  // Cleared entry: invalid, weakly not-taken, target zero.
  localparam btb_entry_t ENTRY_RST = '{valid: 1'b0, tag: '0, target: '0, ctr: 2'b01};

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_d;

  btb_entry_t      btb_rd [BTB_ENTRIES];

  logic [IDX-1:0]  lk_idx;
  logic [TAGW-1:0] lk_tag;
  btb_entry_t      lk_ent;
  logic            lk_hit;
  logic            pred_taken;

  logic [IDX-1:0]  up_idx;
  logic [TAGW-1:0] up_tag;
  btb_entry_t      up_ent;
  logic            up_hit;

  // Low PC bits never take part in indexing and bit 0 of a redirect is forced low.
  logic            unused_bits;
  assign unused_bits = ^{bus.i_upd_pc[1:0], bus.i_redirect_addr[0]};

  // Lookup side: reads the entry as it stood before any same-cycle update.
  assign lk_idx     = pc_q[IDX+1:2];
  assign lk_tag     = pc_q[XLEN-1:IDX+2];
  assign lk_ent     = btb_rd[lk_idx];
  assign lk_hit     = lk_ent.valid && (lk_ent.tag == lk_tag);
  assign pred_taken = lk_hit && lk_ent.ctr[1];

  // Training side: tag compare against the addressed entry.
  assign up_idx = bus.i_upd_pc[IDX+1:2];
  assign up_tag = bus.i_upd_pc[XLEN-1:IDX+2];
  assign up_ent = btb_rd[up_idx];
  assign up_hit = up_ent.valid && (up_ent.tag == up_tag);

  for (genvar gi = 0; gi < BTB_ENTRIES; gi++) begin : g_btb
    btb_entry_t ent_q;
    btb_entry_t ent_d;
    logic       sel;

    assign sel = bus.i_upd_vld && (up_idx == IDX'(gi));

    // Training next state: saturating counter on a hit, allocate on a taken miss.
    always_comb begin
      ent_d = ent_q;
      if (sel) begin
        if (up_hit) begin
          if (bus.i_upd_taken) begin
            ent_d.target = bus.i_upd_target;
            if (ent_q.ctr != 2'b11) ent_d.ctr = ent_q.ctr + 2'd1;
          end else if (ent_q.ctr != 2'b00) begin
            ent_d.ctr = ent_q.ctr - 2'd1;
          end
        end else if (bus.i_upd_taken) begin
          ent_d.valid  = 1'b1;
          ent_d.tag    = up_tag;
          ent_d.target = bus.i_upd_target;
          ent_d.ctr    = 2'b10;
        end
      end
    end

    // Entry storage; reset invalidates and drops any update in flight.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) ent_q <= ENTRY_RST;
      else          ent_q <= ent_d;
    end

    assign btb_rd[gi] = ent_q;
  end

  // Next-PC select: redirect beats stall, stall beats prediction, else sequential.
  always_comb begin
    pc_d = pc_q + XLEN'(4);
    if (bus.i_redirect)  pc_d = {bus.i_redirect_addr[XLEN-1:1], 1'b0};
    else if (bus.i_stall) pc_d = pc_q;
    else if (pred_taken)  pc_d = lk_ent.target;
  end

  // Fetch-address register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) pc_q <= RESET_ADDR;
    else          pc_q <= pc_d;
  end

  assign bus.o_imem_raddr  = pc_q;
  assign bus.o_pred_taken  = pred_taken;
  assign bus.o_pred_target = lk_ent.target;
  assign bus.o_nxt_pc      = pc_d;
  assign bus.o_flush       = bus.i_redirect;

endmodule

// File: doc/pc_predict.md
# pc_predict

Parametrised program-counter stage with a direct-mapped branch target buffer (BTB) and 2-bit saturating direction counters. Each cycle it drives the instruction-fetch address and a next-PC prediction. It accepts redirects (mispredict, jump, or trap) and training updates from the execute stage. It sits in the IF stage, feeding instruction memory and the IF/ID register.

## Interface

- `RESET_ADDR`, 32'h00000000: PC value held during and leaving reset.
- `XLEN`, 32: address width.
- `BTB_ENTRIES`, 16: number of BTB entries; must be a power of two, ≥2. `IDX = log2(BTB_ENTRIES)`.

- `i_clk`  in  1  global clock, rising edge.
- `i_rst_n`  in  1  asynchronous, active-low reset.
- `i_stall`  in  1  hold PC (halt or hazard).
- `i_redirect`  in  1  force next PC to `i_redirect_addr`.
- `i_redirect_addr`  in  XLEN  redirect target.
- `i_upd_vld`  in  1  training update valid; EX resolved a branch or jal.
- `i_upd_pc`  in  XLEN  PC of the resolved instruction.
- `i_upd_target`  in  XLEN  resolved taken target.
- `i_upd_taken`  in  1  resolved direction.
- `o_imem_raddr`  out  XLEN  current fetch address (`pc_q`).
- `o_pred_taken`  out  1  BTB predicts the fetched instruction is taken.
- `o_pred_target`  out  XLEN  predicted target; valid when `o_pred_taken`.
- `o_nxt_pc`  out  XLEN  value `pc_q` loads at the next edge.
- `o_flush`  out  1  flush the IF/ID register.

## Operation

**BTB entry fields:** valid, tag (`pc[XLEN-1:IDX+2]`), target (XLEN bits), ctr (2 bits).

**Lookup** (combinational on `pc_q`):
- Index is `pc_q[IDX+1:2]`.
- `hit` = valid AND tag match.
- `o_pred_taken` = `hit` AND `ctr[1]`.
- `o_pred_target` = entry target.

**Next-PC priority, highest first:**
1. `i_redirect`: `{i_redirect_addr[XLEN-1:1], 1'b0}`.
2. `i_stall`: hold `pc_q`.
3. `o_pred_taken`: `o_pred_target`.
4. Otherwise: `pc_q + 4`, wrapping modulo 2^XLEN.

**Redirect vs. stall:** redirect overrides stall; a redirect is never lost.

**`o_flush`:** equals `i_redirect` combinationally.

**Training** (applied at the clock edge when `i_upd_vld`), at index `i_upd_pc[IDX+1:2]`:
- Tag hit:
  - ctr saturating +1 if taken, −1 if not taken (bounded 00..11).
  - Target is overwritten with `i_upd_target` when taken.
- Tag miss, taken: allocate the entry. valid=1, new tag, target=`i_upd_target`, ctr=2'b10.
- Tag miss, not taken: no change.

**Concurrency:**
- A lookup and an update to the same entry in the same cycle: the lookup sees pre-update contents.
- An update proceeds regardless of `i_stall` and `i_redirect`.

**Width rules:**
- `pc_q` bits [1:0] are not used for indexing.
- No alignment check is performed on predicted targets; targets are stored verbatim.

## Timing

**Reset (asynchronous assert):**
- `pc_q` = `RESET_ADDR` immediately; `o_imem_raddr` = `RESET_ADDR`.
- All valid bits = 0 and all ctrs = 2'b01, so `o_pred_taken` = 0, `o_pred_target` = 0 (targets cleared).
- `o_nxt_pc` = `RESET_ADDR + 4` while `i_stall` and `i_redirect` are low; `o_flush` follows `i_redirect`.

**Reset release:** deassertion is synchronised externally. The first fetch after release is `RESET_ADDR`.

**Latencies:**
- Fetch-address latency: 1 cycle; `o_nxt_pc` appears on `o_imem_raddr` after the next rising edge.
- Prediction is zero-latency, in the same cycle as `o_imem_raddr`.
- Training is visible to lookups from the cycle after the update edge.

**Reset mid-operation:** in-flight updates are discarded and the BTB is fully invalidated.

## Test plan

- **Reset, then sequential fetch:** hold `i_rst_n`=0, then release with `RESET_ADDR`=0x100 and no other inputs.
  - `o_imem_raddr` = 0x100, 0x104, 0x108 …
  - `o_pred_taken` = 0 throughout.
- **Allocate and predict:** update `i_upd_pc`=0x108, taken, target=0x200. Then fetch 0x108.
  - `o_pred_taken`=1 and `o_pred_target`=0x200.
  - Next `o_imem_raddr` = 0x200.
- **Counter hysteresis:** after allocation (ctr 10), send two not-taken updates at 0x108.
  - First update: ctr 01, fetch of 0x108 predicts not taken (→0x10C).
  - Then three taken updates: ctr saturates at 11; one not-taken update leaves ctr 10, still predicts taken.
- **Redirect over stall:** assert `i_stall`=1 and `i_redirect`=1 with address 0x303 in the same cycle.
  - `o_flush`=1.
  - Next `o_imem_raddr` = 0x302.
  - With stall alone, the PC holds for N cycles.
- **Alias, tag mismatch:** with `BTB_ENTRIES`=16, allocate 0x108 taken. Fetch 0x148 (same index, different tag).
  - `o_pred_taken`=0, next fetch = 0x14C.
  - A taken update at 0x148 replaces the entry; 0x108 then misses.
- **Async reset mid-run:** pull `i_rst_n` low between edges while a trained entry exists.
  - `o_imem_raddr` returns to `RESET_ADDR` without waiting for a clock edge.
  - After release, the previously trained PC predicts not taken.
